// File: rtl/emu_osc_model.sv
// rtl/emu_osc_model.sv - emulated-time oscillator model with handshaked half-period reconfiguration
// Optional LFSR half-period jitter is enabled by defining EMU_OSC_JITTER_EN.
module emu_osc_model #(
    parameter int DT_WIDTH     = 27,
    parameter int T_HI_DEFAULT = 100,
    parameter int T_LO_DEFAULT = 100,
    parameter int JITTER_BITS  = 4
) (
    input  logic                emu_clk,
    input  logic                emu_rst,
    input  logic                osc_en,
    input  logic [DT_WIDTH-1:0] emu_dt,
    output logic [DT_WIDTH-1:0] dt_req,
    output logic                clk_val,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [DT_WIDTH-1:0] cfg_t_hi,
    input  logic [DT_WIDTH-1:0] cfg_t_lo,
    output logic                dt_err
);

    typedef enum logic [1:0] {ST_OFF, ST_LO, ST_HI} state_t;

    state_t              state_q, state_d;
    logic [DT_WIDTH-1:0] rem_q, rem_d;
    logic [DT_WIDTH-1:0] dt_req_q, dt_req_d;
    logic [DT_WIDTH-1:0] act_hi_q, act_hi_d, act_lo_q, act_lo_d;
    logic [DT_WIDTH-1:0] shd_hi_q, shd_hi_d, shd_lo_q, shd_lo_d;
    logic                pending_q, pending_d;
    logic                clk_val_q, clk_val_d;
    logic                dt_err_q, dt_err_d;
    logic                edge_hit;
    logic [JITTER_BITS-1:0] jitter;

`ifdef EMU_OSC_JITTER_EN
    logic [15:0] lfsr_q, lfsr_d;

    // Galois form of x^16+x^14+x^13+x^11+1, one step per modelled edge
    always_comb begin
        lfsr_d = lfsr_q;
        if (edge_hit) begin
            lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
        end
    end

    always_ff @(posedge emu_clk) begin
        if (emu_rst) begin
            lfsr_q <= 16'hACE1;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign jitter = lfsr_q[JITTER_BITS-1:0];
`else
    assign jitter = '0;
`endif

    always_comb begin
        logic [DT_WIDTH-1:0] next_hi, next_lo, base;
        logic [DT_WIDTH:0]   sum;
        logic                apply;

        state_d   = state_q;
        rem_d     = rem_q;
        act_hi_d  = act_hi_q;
        act_lo_d  = act_lo_q;
        shd_hi_d  = shd_hi_q;
        shd_lo_d  = shd_lo_q;
        pending_d = pending_q;
        clk_val_d = clk_val_q;
        dt_err_d  = dt_err_q;
        edge_hit  = 1'b0;
        apply     = 1'b0;
        base      = '0;
        sum       = '0;

        // A pending shadow governs the half-period that starts at the apply point
        next_hi = pending_q ? shd_hi_q : act_hi_q;
        next_lo = pending_q ? shd_lo_q : act_lo_q;

        case (state_q)
            ST_OFF: begin
                clk_val_d = 1'b0;
                if (osc_en) begin
                    state_d = ST_LO;
                    rem_d   = next_lo;
                    apply   = 1'b1;
                end
            end
            default: begin
                if (!osc_en) begin
                    state_d   = ST_OFF;
                    clk_val_d = 1'b0;
                end else if (emu_dt != '0) begin
                    if (emu_dt < rem_q) begin
                        rem_d = rem_q - emu_dt;
                    end else begin
                        edge_hit = 1'b1;
                        apply    = 1'b1;
                        if (emu_dt > rem_q) begin
                            dt_err_d = 1'b1;
                        end
                        if (state_q == ST_LO) begin
                            state_d   = ST_HI;
                            clk_val_d = 1'b1;
                            base      = next_hi;
                        end else begin
                            state_d   = ST_LO;
                            clk_val_d = 1'b0;
                            base      = next_lo;
                        end
                        sum   = {1'b0, base} + {{(DT_WIDTH + 1 - JITTER_BITS){1'b0}}, jitter};
                        rem_d = sum[DT_WIDTH] ? {DT_WIDTH{1'b1}} : sum[DT_WIDTH-1:0];
                    end
                end
            end
        endcase

        if (apply && pending_q) begin
            act_hi_d  = shd_hi_q;
            act_lo_d  = shd_lo_q;
            pending_d = 1'b0;
        end

        // Accept only when idle, so an accept never coincides with an apply
        if (cfg_valid && !pending_q) begin
            shd_hi_d  = (cfg_t_hi == '0) ? DT_WIDTH'(1) : cfg_t_hi;
            shd_lo_d  = (cfg_t_lo == '0) ? DT_WIDTH'(1) : cfg_t_lo;
            pending_d = 1'b1;
        end

        dt_req_d = (state_d == ST_OFF) ? {DT_WIDTH{1'b1}} : rem_d;
    end

    always_ff @(posedge emu_clk) begin
        if (emu_rst) begin
            state_q   <= ST_LO;
            rem_q     <= DT_WIDTH'(T_LO_DEFAULT);
            dt_req_q  <= {DT_WIDTH{1'b1}};
            act_hi_q  <= DT_WIDTH'(T_HI_DEFAULT);
            act_lo_q  <= DT_WIDTH'(T_LO_DEFAULT);
            shd_hi_q  <= DT_WIDTH'(T_HI_DEFAULT);
            shd_lo_q  <= DT_WIDTH'(T_LO_DEFAULT);
            pending_q <= 1'b0;
            clk_val_q <= 1'b0;
            dt_err_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            rem_q     <= rem_d;
            dt_req_q  <= dt_req_d;
            act_hi_q  <= act_hi_d;
            act_lo_q  <= act_lo_d;
            shd_hi_q  <= shd_hi_d;
            shd_lo_q  <= shd_lo_d;
            pending_q <= pending_d;
            clk_val_q <= clk_val_d;
            dt_err_q  <= dt_err_d;
        end
    end

    assign dt_req    = dt_req_q;
    assign clk_val   = clk_val_q;
    assign cfg_ready = !pending_q;
    assign dt_err    = dt_err_q;

endmodule

// File: tb/tb_emu_osc_model.sv
// tb/tb_emu_osc_model.sv - directed vector bench for emu_osc_model
module tb_emu_osc_model;

    localparam int W = 27;
    localparam logic [W-1:0] ONES = {W{1'b1}};

    logic         emu_clk = 1'b0;
    logic         emu_rst;
    logic         osc_en;
    logic [W-1:0] emu_dt;
    logic [W-1:0] dt_req;
    logic         clk_val;
    logic         cfg_valid;
    logic         cfg_ready;
    logic [W-1:0] cfg_t_hi;
    logic [W-1:0] cfg_t_lo;
    logic         dt_err;

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        logic         en;
        logic [W-1:0] dt;
        logic         cv;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic [W-1:0] x_req;
        logic         x_clk;
        logic         x_rdy;
        logic         x_err;
    } vec_t;

    vec_t tbl[$];

    emu_osc_model dut (
        .emu_clk  (emu_clk),
        .emu_rst  (emu_rst),
        .osc_en   (osc_en),
        .emu_dt   (emu_dt),
        .dt_req   (dt_req),
        .clk_val  (clk_val),
        .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready),
        .cfg_t_hi (cfg_t_hi),
        .cfg_t_lo (cfg_t_lo),
        .dt_err   (dt_err)
    );

    always #5 emu_clk = ~emu_clk;

    function automatic void add(input logic en, input int dt, input logic cv, input int hi,
                                input int lo, input logic [W-1:0] xr, input logic xc,
                                input logic xy, input logic xe);
        vec_t v;
        v.en = en; v.dt = W'(dt); v.cv = cv; v.hi = W'(hi); v.lo = W'(lo);
        v.x_req = xr; v.x_clk = xc; v.x_rdy = xy; v.x_err = xe;
        tbl.push_back(v);
    endfunction

    task automatic step();
        @(posedge emu_clk);
        #1;
    endtask

    task automatic check(input string name, input logic [W-1:0] xr, input logic xc,
                         input logic xy, input logic xe);
        n_vec++;
        if (dt_req !== xr || clk_val !== xc || cfg_ready !== xy || dt_err !== xe) begin
            n_bad++;
            $display("FAIL %s: got dt_req=%0d clk_val=%0b cfg_ready=%0b dt_err=%0b, want dt_req=%0d clk_val=%0b cfg_ready=%0b dt_err=%0b",
                     name, dt_req, clk_val, cfg_ready, dt_err, xr, xc, xy, xe);
        end
    endtask

    task automatic drive(input logic en, input logic [W-1:0] dt, input logic cv,
                         input logic [W-1:0] hi, input logic [W-1:0] lo);
        osc_en = en; emu_dt = dt; cfg_valid = cv; cfg_t_hi = hi; cfg_t_lo = lo;
    endtask

    initial begin
        //  en  dt   cv hi   lo   dt_req clk rdy err
        add(0,    0, 0,  0,   0, ONES, 0, 1, 0);   // reset LO falls to OFF
        add(0,  500, 0,  0,   0, ONES, 0, 1, 0);   // emu_dt ignored while off
        add(1,    0, 0,  0,   0, W'(100), 0, 1, 0);
        add(1,  100, 0,  0,   0, W'(100), 1, 1, 0);
        add(1,  100, 0,  0,   0, W'(100), 0, 1, 0);
        add(1,  100, 0,  0,   0, W'(100), 1, 1, 0);
        add(1,  100, 0,  0,   0, W'(100), 0, 1, 0);
        add(1,   30, 0,  0,   0, W'(70),  0, 1, 0);
        add(1,   30, 0,  0,   0, W'(40),  0, 1, 0);
        add(1,    0, 0,  0,   0, W'(40),  0, 1, 0);
        add(1,   40, 0,  0,   0, W'(100), 1, 1, 0);
        add(1,  100, 0,  0,   0, W'(100), 0, 1, 0);
        add(1,   50, 1, 20,   5, W'(50),  0, 0, 0);  // accept mid-LO
        add(1,   10, 1,  7,   9, W'(40),  0, 0, 0);  // held off
        add(1,   40, 0,  0,   0, W'(20),  1, 1, 0);  // applied at edge
        add(1,   20, 0,  0,   0, W'(5),   0, 1, 0);
        add(1,    5, 0,  0,   0, W'(20),  1, 1, 0);
        add(1,    5, 0,  0,   0, W'(15),  1, 1, 0);
        add(1,   15, 1,  0, 100, W'(5),   0, 0, 0);  // accept + edge: old act_lo
        add(1,    5, 0,  0,   0, W'(1),   1, 1, 0);  // zero hi clamped to 1
        add(1,    1, 0,  0,   0, W'(100), 0, 1, 0);
        add(1,    0, 1, 100, 100, W'(100), 0, 0, 0);
        add(1,  100, 0,  0,   0, W'(100), 1, 1, 0);
        add(1,  150, 0,  0,   0, W'(100), 0, 1, 1);  // overshoot
        add(1,  100, 0,  0,   0, W'(100), 1, 1, 1);
        add(1,   30, 0,  0,   0, W'(70),  1, 1, 1);
        add(0,   30, 0,  0,   0, ONES,    0, 1, 1);  // mid-HI disable
        add(0,    0, 0,  0,   0, ONES,    0, 1, 1);
        add(1,    0, 0,  0,   0, W'(100), 0, 1, 1);
        add(1,  100, 0,  0,   0, W'(100), 1, 1, 1);
        add(0,    0, 0,  0,   0, ONES,    0, 1, 1);
        add(0,    0, 1, 10,   3, ONES,    0, 0, 1);  // accept while off
        add(1,    0, 0,  0,   0, W'(3),   0, 1, 1);  // applied on enable
        add(1,    3, 0,  0,   0, W'(10),  1, 1, 1);
        add(1,   10, 0,  0,   0, W'(3),   0, 1, 1);

        emu_rst = 1'b1;
        drive(1'b0, '0, 1'b0, '0, '0);
        step();
        step();
        check("reset", ONES, 1'b0, 1'b1, 1'b0);
        emu_rst = 1'b0;

        foreach (tbl[i]) begin
            drive(tbl[i].en, tbl[i].dt, tbl[i].cv, tbl[i].hi, tbl[i].lo);
            step();
            check($sformatf("vec%0d", i), tbl[i].x_req, tbl[i].x_clk, tbl[i].x_rdy, tbl[i].x_err);
        end

        // Reset during a pending handshake discards the shadow and clears dt_err
        drive(1'b1, '0, 1'b1, W'(50), W'(50));
        step();
        check("pend_before_rst", W'(3), 1'b0, 1'b0, 1'b1);
        emu_rst = 1'b1;
        drive(1'b0, '0, 1'b0, '0, '0);
        step();
        check("rst_mid_cfg", ONES, 1'b0, 1'b1, 1'b0);
        emu_rst = 1'b0;
        step();
        check("off_after_rst", ONES, 1'b0, 1'b1, 1'b0);
        drive(1'b1, '0, 1'b0, '0, '0);
        step();
        check("defaults_after_rst", W'(100), 1'b0, 1'b1, 1'b0);
        drive(1'b1, W'(100), 1'b0, '0, '0);
        step();
        check("hi_default_after_rst", W'(100), 1'b1, 1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
